// File: rtl/mem_word_bridge_if.sv
// Bundle of the core's instruction/data word ports and the 64-bit pmem port.
// The bridge uses the slave modport; the core/pmem side uses master.
interface mem_word_bridge_if;
    logic        instr_read;
    logic [31:0] instr_mem_address;
    logic        instr_mem_resp;
    logic [31:0] instr_mem_rdata;

    logic        data_read;
    logic        data_write;
    logic [3:0]  data_mbe;
    logic [31:0] data_mem_address;
    logic [31:0] data_mem_wdata;
    logic        data_mem_resp;
    logic [31:0] data_mem_rdata;

    logic        pmem_read;
    logic        pmem_write;
    logic [31:0] pmem_address;
    logic [63:0] pmem_wdata;
    logic        pmem_resp;
    logic [63:0] pmem_rdata;

    modport slave (
        input  instr_read, instr_mem_address,
        input  data_read, data_write, data_mbe, data_mem_address, data_mem_wdata,
        input  pmem_resp, pmem_rdata,
        output instr_mem_resp, instr_mem_rdata,
        output data_mem_resp, data_mem_rdata,
        output pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    modport master (
        output instr_read, instr_mem_address,
        output data_read, data_write, data_mbe, data_mem_address, data_mem_wdata,
        output pmem_resp, pmem_rdata,
        input  instr_mem_resp, instr_mem_rdata,
        input  data_mem_resp, data_mem_rdata,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata
    );
endinterface

// File: rtl/mem_word_bridge.sv
// Arbitrates instruction/data word requests onto a 64-bit pmem port; stores
// are done as a read-modify-write of the containing beat.
module mem_word_bridge (
    input  logic             clk,
    input  logic             rst,
    mem_word_bridge_if.slave bus
);
    typedef enum logic [2:0] {IDLE, I_RD, D_RD, D_RMW_RD, D_RMW_WR, RESP} state_t;

    state_t      state, state_d;
    logic        last_data, last_data_d;
    logic        grant_data, grant_data_d;
    logic        half_hi, half_hi_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  mbe_q, mbe_d;

    logic        pmem_read_q, pmem_read_d;
    logic        pmem_write_q, pmem_write_d;
    logic [31:0] pmem_address_q, pmem_address_d;
    logic [63:0] pmem_wdata_q, pmem_wdata_d;
    logic        instr_resp_q, instr_resp_d;
    logic        data_resp_q, data_resp_d;
    logic [31:0] instr_rdata_q, instr_rdata_d;
    logic [31:0] data_rdata_q, data_rdata_d;

    logic        instr_req, data_req, take_data;
    logic [31:0] rd_word;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^{bus.instr_mem_address[1:0], bus.data_mem_address[1:0]};

    function automatic logic [31:0] merge_word(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  be);
        logic [31:0] w;
        w = old_w;
        for (int i = 0; i < 4; i++)
            if (be[i]) w[8*i +: 8] = new_w[8*i +: 8];
        return w;
    endfunction

    function automatic logic [63:0] merge_beat(input logic [63:0] beat,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  be,
                                               input logic        hi);
        logic [63:0] b;
        b = beat;
        if (hi) b[63:32] = merge_word(beat[63:32], new_w, be);
        else    b[31:0]  = merge_word(beat[31:0],  new_w, be);
        return b;
    endfunction

    assign instr_req = bus.instr_read;
    assign data_req  = bus.data_read | bus.data_write;
    // On a tie the port that was not served last wins.
    assign take_data = data_req && (!instr_req || !last_data);
    assign rd_word   = half_hi ? bus.pmem_rdata[63:32] : bus.pmem_rdata[31:0];

    always_comb begin
        state_d        = state;
        last_data_d    = last_data;
        grant_data_d   = grant_data;
        half_hi_d      = half_hi;
        wdata_d        = wdata_q;
        mbe_d          = mbe_q;
        pmem_read_d    = pmem_read_q;
        pmem_write_d   = pmem_write_q;
        pmem_address_d = pmem_address_q;
        pmem_wdata_d   = pmem_wdata_q;
        instr_resp_d   = 1'b0;
        data_resp_d    = 1'b0;
        instr_rdata_d  = instr_rdata_q;
        data_rdata_d   = data_rdata_q;

        case (state)
            IDLE: begin
                if (take_data) begin
                    grant_data_d   = 1'b1;
                    half_hi_d      = bus.data_mem_address[2];
                    wdata_d        = bus.data_mem_wdata;
                    mbe_d          = bus.data_mbe;
                    pmem_address_d = {bus.data_mem_address[31:3], 3'b000};
                    pmem_read_d    = 1'b1;
                    state_d        = bus.data_write ? D_RMW_RD : D_RD;
                end else if (instr_req) begin
                    grant_data_d   = 1'b0;
                    half_hi_d      = bus.instr_mem_address[2];
                    pmem_address_d = {bus.instr_mem_address[31:3], 3'b000};
                    pmem_read_d    = 1'b1;
                    state_d        = I_RD;
                end
            end
            I_RD, D_RD: begin
                if (bus.pmem_resp) begin
                    pmem_read_d = 1'b0;
                    state_d     = RESP;
                    if (state == D_RD) begin
                        data_resp_d  = 1'b1;
                        data_rdata_d = rd_word;
                    end else begin
                        instr_resp_d  = 1'b1;
                        instr_rdata_d = rd_word;
                    end
                end
            end
            D_RMW_RD: begin
                if (bus.pmem_resp) begin
                    pmem_read_d  = 1'b0;
                    pmem_write_d = 1'b1;
                    pmem_wdata_d = merge_beat(bus.pmem_rdata, wdata_q, mbe_q, half_hi);
                    state_d      = D_RMW_WR;
                end
            end
            D_RMW_WR: begin
                if (bus.pmem_resp) begin
                    pmem_write_d = 1'b0;
                    data_resp_d  = 1'b1;
                    data_rdata_d = half_hi ? pmem_wdata_q[63:32] : pmem_wdata_q[31:0];
                    state_d      = RESP;
                end
            end
            RESP: begin
                last_data_d = grant_data;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            last_data      <= 1'b0;
            pmem_read_q    <= 1'b0;
            pmem_write_q   <= 1'b0;
            pmem_address_q <= '0;
            pmem_wdata_q   <= '0;
            instr_resp_q   <= 1'b0;
            data_resp_q    <= 1'b0;
            instr_rdata_q  <= '0;
            data_rdata_q   <= '0;
        end else begin
            state          <= state_d;
            last_data      <= last_data_d;
            pmem_read_q    <= pmem_read_d;
            pmem_write_q   <= pmem_write_d;
            pmem_address_q <= pmem_address_d;
            pmem_wdata_q   <= pmem_wdata_d;
            instr_resp_q   <= instr_resp_d;
            data_resp_q    <= data_resp_d;
            instr_rdata_q  <= instr_rdata_d;
            data_rdata_q   <= data_rdata_d;
        end
    end

    // Request context is only read after IDLE has loaded it, so it needs no reset.
    always_ff @(posedge clk) begin
        grant_data <= grant_data_d;
        half_hi    <= half_hi_d;
        wdata_q    <= wdata_d;
        mbe_q      <= mbe_d;
    end

    assign bus.pmem_read       = pmem_read_q;
    assign bus.pmem_write      = pmem_write_q;
    assign bus.pmem_address    = pmem_address_q;
    assign bus.pmem_wdata      = pmem_wdata_q;
    assign bus.instr_mem_resp  = instr_resp_q;
    assign bus.instr_mem_rdata = instr_rdata_q;
    assign bus.data_mem_resp   = data_resp_q;
    assign bus.data_mem_rdata  = data_rdata_q;
endmodule
